uart_autobaud: RTL and testbench

Automatic baud-rate detector for the UART receive path. When armed, it watches the serial line for one 0x55 sync frame and measures the bit period in clock cycles. It validates the measurement and publishes the result as `clk_per_bit`, which drives the `clk_per_bit` input of the UART transmitter/receiver pair. This lets the design lock to a host's baud rate without a configuration register.

---
 rtl/uart_autobaud.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_autobaud.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the bit period of a 0x55 sync frame on the serial line
// and publishes it as clk_per_bit for the UART TX/RX pair.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   start        one-cycle pulse that arms a measurement (ignored while busy)
//   abort        returns to IDLE from any state without a done/error pulse
//   RX_dataIn    raw asynchronous serial line, idle high
//   clk_per_bit  last accepted bit period in clocks
//   locked       high once a measurement succeeds, cleared on start
//   busy         high in every state except IDLE
//   done         one-cycle pulse on a successful measurement
//   error        one-cycle pulse on a failed measurement
//   err_code     00 ok, 01 timeout, 10 out of range, 11 inconsistent intervals
module uart_autobaud #(
    parameter int CLK_BITS    = 8,
    parameter int DEFAULT_CPB = 87,
    parameter int MIN_CPB     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                RX_dataIn,
    output logic [CLK_BITS-1:0] clk_per_bit,
    output logic                locked,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code
);
    localparam int IVL_W = CLK_BITS + 1;   // running interval counter
    localparam int INC_W = CLK_BITS + 2;   // ivl+1 held without wrapping
    localparam int TOT_W = CLK_BITS + 4;   // F1..F5 span counter
    localparam int RND_W = CLK_BITS + 5;   // total+4 without wrapping
    localparam int CPB_W = CLK_BITS + 2;   // rounded result before range check

    localparam logic [IVL_W-1:0] IVL_MAX = {IVL_W{1'b1}};
    localparam logic [CPB_W-1:0] CPB_MIN = CPB_W'(MIN_CPB);
    localparam logic [CPB_W-1:0] CPB_MAX = CPB_W'((2 ** CLK_BITS) - 1);

    localparam logic [1:0] CODE_OK    = 2'b00;
    localparam logic [1:0] CODE_TMO   = 2'b01;
    localparam logic [1:0] CODE_RANGE = 2'b10;
    localparam logic [1:0] CODE_BAD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_HUNT    = 3'd2,
        ST_MEASURE = 3'd3,
        ST_CHECK   = 3'd4,
        ST_REPORT  = 3'd5
    } state_t;

    // Magnitude of the difference between two unsigned interval values.
    function automatic logic [INC_W-1:0] abs_diff(input logic [INC_W-1:0] a,
                                                   input logic [INC_W-1:0] b);
        if (a >= b) begin
            abs_diff = a - b;
        end else begin
            abs_diff = b - a;
        end
    endfunction

    state_t              r_state, w_next_state;
    logic                r_sync1, r_sync2, r_prev;
    logic [IVL_W-1:0]    r_ivl, w_ivl;
    logic [TOT_W-1:0]    r_total, w_total;
    logic [1:0]          r_fall_cnt, w_fall_cnt;
    logic [INC_W-1:0]    r_i1, w_i1;
    logic                r_bad, w_bad;
    logic [CLK_BITS-1:0] r_cpb, w_cpb;
    logic [1:0]          r_code, w_code;
    logic [CLK_BITS-1:0] r_clk_per_bit, w_clk_per_bit;
    logic                r_locked, w_locked;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_error, w_error;
    logic [1:0]          r_err_code, w_err_code;

    logic                w_fall;
    logic [INC_W-1:0]    w_ivl_inc;
    logic [INC_W-1:0]    w_diff;
    logic [CPB_W-1:0]    w_cpb_calc;

    // Falling edge seen on the synchronized line.
    assign w_fall     = r_prev & ~r_sync2;
    // Interval length including the cycle of the edge that ends it.
    assign w_ivl_inc  = {1'b0, r_ivl} + INC_W'(1);
    assign w_diff     = abs_diff(w_ivl_inc, r_i1);
    // Span covers 8 bit times; adding 4 before dividing rounds to nearest.
    assign w_cpb_calc = CPB_W'(({1'b0, r_total} + RND_W'(4)) >> 3);

    // Two-flop synchronizer plus the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= RX_dataIn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Next-state, measurement datapath and output values.
    always_comb begin
        w_next_state  = r_state;
        w_ivl         = r_ivl;
        w_total       = r_total;
        w_fall_cnt    = r_fall_cnt;
        w_i1          = r_i1;
        w_bad         = r_bad;
        w_cpb         = r_cpb;
        w_code        = r_code;
        w_clk_per_bit = r_clk_per_bit;
        w_locked      = r_locked;
        w_done        = 1'b0;
        w_error       = 1'b0;
        w_err_code    = r_err_code;

        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_locked     = 1'b0;
                        w_err_code   = CODE_OK;
                        w_next_state = ST_ARM;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    // A low line here is not an edge; wait for idle-high first.
                    if (r_sync2) begin
                        w_next_state = ST_HUNT;
                    end else begin
                        w_next_state = ST_ARM;
                    end
                end
                ST_HUNT: begin
                    if (w_fall) begin
                        w_ivl        = '0;
                        w_total      = '0;
                        w_fall_cnt   = 2'd0;
                        w_bad        = 1'b0;
                        w_next_state = ST_MEASURE;
                    end else begin
                        w_next_state = ST_HUNT;
                    end
                end
                ST_MEASURE: begin
                    w_ivl   = r_ivl + IVL_W'(1);
                    w_total = r_total + TOT_W'(1);
                    if (w_fall) begin
                        w_ivl      = '0;
                        w_fall_cnt = r_fall_cnt + 2'd1;
                        if (r_fall_cnt == 2'd0) begin
                            w_i1 = w_ivl_inc;
                        end else if (w_diff > (r_i1 >> 2)) begin
                            w_bad = 1'b1;
                        end else begin
                            w_bad = r_bad;
                        end
                        // Fourth captured interval ends at F5.
                        if (r_fall_cnt == 2'd3) begin
                            w_next_state = ST_CHECK;
                        end else begin
                            w_next_state = ST_MEASURE;
                        end
                    end else if (r_ivl == IVL_MAX) begin
                        w_code       = CODE_TMO;
                        w_next_state = ST_REPORT;
                    end else begin
                        w_next_state = ST_MEASURE;
                    end
                end
                ST_CHECK: begin
                    w_cpb = w_cpb_calc[CLK_BITS-1:0];
                    if (r_bad) begin
                        w_code = CODE_BAD;
                    end else if ((w_cpb_calc < CPB_MIN) || (w_cpb_calc > CPB_MAX)) begin
                        w_code = CODE_RANGE;
                    end else begin
                        w_code = CODE_OK;
                    end
                    w_next_state = ST_REPORT;
                end
                ST_REPORT: begin
                    if (r_code == CODE_OK) begin
                        w_done        = 1'b1;
                        w_clk_per_bit = r_cpb;
                        w_locked      = 1'b1;
                    end else begin
                        w_error    = 1'b1;
                        w_err_code = r_code;
                    end
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end

        w_busy = (w_next_state != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_ivl         <= '0;
            r_total       <= '0;
            r_fall_cnt    <= 2'd0;
            r_i1          <= '0;
            r_bad         <= 1'b0;
            r_cpb         <= '0;
            r_code        <= CODE_OK;
            r_clk_per_bit <= CLK_BITS'(DEFAULT_CPB);
            r_locked      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_err_code    <= CODE_OK;
        end else begin
            r_state       <= w_next_state;
            r_ivl         <= w_ivl;
            r_total       <= w_total;
            r_fall_cnt    <= w_fall_cnt;
            r_i1          <= w_i1;
            r_bad         <= w_bad;
            r_cpb         <= w_cpb;
            r_code        <= w_code;
            r_clk_per_bit <= w_clk_per_bit;
            r_locked      <= w_locked;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_error       <= w_error;
            r_err_code    <= w_err_code;
        end
    end

    assign clk_per_bit = r_clk_per_bit;
    assign locked      = r_locked;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: table of sync-frame shapes with expected outcomes,
// a scoreboard queue of expected done/error pulses checked by a monitor, and
// hand-written sequences for ignored start, abort and asynchronous reset.
module tb_uart_autobaud;
    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       rx;
    logic [7:0] clk_per_bit;
    logic       locked;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    uart_autobaud #(
        .CLK_BITS   (8),
        .DEFAULT_CPB(87),
        .MIN_CPB    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .RX_dataIn  (rx),
        .clk_per_bit(clk_per_bit),
        .locked     (locked),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit ok;
        int cpb;
        int code;
    } exp_t;

    typedef struct {
        string name;
        int    lo;
        int    hi;
        int    mid_lo;
        int    mid_hi;
        bit    ok;
        bit    tmo;
        int    cpb;
        int    code;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];

    int n_tests  = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    int m_cpb    = 87;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (done || error)) begin
                n_pulses++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: done=%0d error=%0d code=%0d at cycle %0d, required no pulse",
                             done, error, err_code, cyc);
                end else begin
                    e = sb.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_done", int'(done), int'(e.ok));
                    check("pulse_error", int'(error), int'(!e.ok));
                    check("pulse_clk_per_bit", int'(clk_per_bit), e.ok ? e.cpb : m_cpb);
                    check("pulse_locked", int'(locked), int'(e.ok));
                    check("pulse_err_code", int'(err_code), e.code);
                    if (e.ok) m_cpb = e.cpb;
                end
            end
        end
    endtask

    task automatic send(input int seg[10]);
        for (int i = 0; i < 10; i++) begin
            rx = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (seg[i]) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic build(input vec_t v, output int seg[10]);
        for (int i = 0; i < 4; i++) begin
            seg[2*i]   = (i == 2) ? v.mid_lo : v.lo;
            seg[2*i+1] = (i == 2) ? v.mid_hi : v.hi;
        end
        seg[8] = v.lo;
        seg[9] = v.hi;
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (sb.size() > 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("pending_expectations", sb.size(), 0);
        sb.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idle, input int start_at);
        int   seg[10];
        int   sum8;
        exp_t e;
        build(v, seg);
        pulse_start();
        check({v.name, "_busy_after_start"}, int'(busy), 1);
        check({v.name, "_locked_cleared"}, int'(locked), 0);
        check({v.name, "_err_code_cleared"}, int'(err_code), 0);
        repeat (idle) @(negedge clk);
        sum8 = 0;
        for (int i = 0; i < 8; i++) sum8 += seg[i];
        // F1 driven now is sampled at the next edge; timeout pulse follows
        // detection by 2^(CLK_BITS+1)+1, success/failure lands at F5 edge +4.
        e.cyc  = v.tmo ? (cyc + 516) : (cyc + sum8 + 5);
        e.ok   = v.ok;
        e.cpb  = v.cpb;
        e.code = v.code;
        sb.push_back(e);
        if (start_at >= 0) begin
            fork
                begin
                    repeat (start_at) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            join_none
        end
        send(seg);
        wait_drain(1200);
        repeat (3) @(negedge clk);
        check({v.name, "_err_code_held"}, int'(err_code), v.code);
        check({v.name, "_locked_after"}, int'(locked), int'(v.ok));
        check({v.name, "_busy_after"}, int'(busy), 0);
        check({v.name, "_clk_per_bit_after"}, int'(clk_per_bit), m_cpb);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int seg16[10];
        int p0;

        //            name        lo   hi   mlo  mhi  ok    tmo   cpb  code
        vecs[0]  = '{"cpb16",     16,  16,  16,  16,  1'b1, 1'b0, 16,  0};
        vecs[1]  = '{"jitter",    86,  88,  86,  88,  1'b1, 1'b0, 87,  0};
        vecs[2]  = '{"min4",      4,   4,   4,   4,   1'b1, 1'b0, 4,   0};
        vecs[3]  = '{"cpb3",      3,   3,   3,   3,   1'b0, 1'b0, 0,   2};
        vecs[4]  = '{"cpb2",      2,   2,   2,   2,   1'b0, 1'b0, 0,   2};
        vecs[5]  = '{"max255",    255, 255, 255, 255, 1'b1, 1'b0, 255, 0};
        vecs[6]  = '{"tol_hi",    16,  16,  20,  20,  1'b1, 1'b0, 17,  0};
        vecs[7]  = '{"tol_lo",    16,  16,  12,  12,  1'b1, 1'b0, 15,  0};
        vecs[8]  = '{"bad_hi",    16,  16,  20,  21,  1'b0, 1'b0, 0,   3};
        vecs[9]  = '{"incons",    16,  16,  24,  24,  1'b0, 1'b0, 0,   3};
        vecs[10] = '{"bad_prio",  2,   2,   4,   4,   1'b0, 1'b0, 0,   3};
        vecs[11] = '{"tmo300",    300, 300, 300, 300, 1'b0, 1'b1, 0,   1};
        vecs[12] = '{"tmo_idle",  10,  700, 10,  700, 1'b0, 1'b1, 0,   1};

        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        rx    = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_clk_per_bit", int'(clk_per_bit), 87);
        check("reset_locked", int'(locked), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_error", int'(error), 0);
        check("reset_err_code", int'(err_code), 0);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], (i == 0) ? 50 : 10, -1);
        end

        // start pulsed mid-MEASURE must not restart the measurement.
        run_vec(vecs[0], 10, 40);

        // abort in HUNT: back to IDLE, frame afterwards produces nothing.
        build(vecs[0], seg16);
        pulse_start();
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        p0 = n_pulses;
        send(seg16);
        repeat (20) @(negedge clk);
        check("abort_no_pulse", n_pulses - p0, 0);
        check("abort_clk_per_bit", int'(clk_per_bit), m_cpb);
        check("abort_locked", int'(locked), 0);

        // start together with abort: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);

        // Lock first, then reset in the middle of MEASURE.
        run_vec(vecs[0], 10, -1);
        pulse_start();
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_clk_per_bit", int'(clk_per_bit), 87);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_locked", int'(locked), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_error", int'(error), 0);
        m_cpb = 87;
        rx    = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_pulse", int'(done) + int'(error), 0);

        // Recovery after reset.
        run_vec(vecs[1], 10, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
